led_ctrl: RTL and testbench

LED_CTRL -- requirements
Module: led_ctrl

---
 rtl/led_ctrl_pkg.sv | 32 +++
 rtl/led_ctrl_if.sv | 19 +
 rtl/led_period_timer.sv | 32 +++
 rtl/led_ctrl.sv | 152 +++++++++++++++
 tb/tb_led_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED pattern controller.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_SHIFT  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0]  ADDR_CTRL    = 2'd0;
  localparam logic [1:0]  ADDR_PATTERN = 2'd1;
  localparam logic [1:0]  ADDR_PERIOD  = 2'd2;
  localparam logic [1:0]  ADDR_SHOW    = 2'd3;

  localparam logic [31:0] LED_OFF_DEFAULT = 32'hFFFF_FFFF;

  // Only BLINK and SHIFT drive the frame engine; the reserved code behaves as MANUAL.
  function automatic logic engine_mode(input mode_e m);
    return (m == MODE_BLINK) || (m == MODE_SHIFT);
  endfunction

  function automatic logic [31:0] rotl1(input logic [31:0] v);
    return {v[30:0], v[31]};
  endfunction

endpackage

// File: rtl/led_ctrl_if.sv
// CPU register port and LED data-register write port of the LED controller.
interface led_ctrl_if;
  logic        cpu_we;
  logic [1:0]  cpu_addr;
  logic [31:0] cpu_wd;
  logic [31:0] cpu_rd;
  logic        led_we;
  logic [31:0] led_wd;

  modport master (
    output cpu_we, cpu_addr, cpu_wd,
    input  cpu_rd, led_we, led_wd
  );

  modport slave (
    input  cpu_we, cpu_addr, cpu_wd,
    output cpu_rd, led_we, led_wd
  );
endinterface

// File: rtl/led_period_timer.sv
// Frame period counter: raises tick on the last cycle of each period_eff window.
module led_period_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_eff;
  logic             at_end;

  // A zero period would never match, so it runs at one frame per cycle.
  assign period_eff = (period_i == '0) ? CNT_W'(1) : period_i;
  assign at_end     = (cnt_q == period_eff - CNT_W'(1));
  assign tick_o     = run_i && !clr_i && at_end;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!run_i || clr_i || at_end) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_ctrl.sv
// LED controller: CPU-programmed manual/blink/shift frames pushed to an LED data register.
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter logic [31:0] OFF_VALUE = LED_OFF_DEFAULT,
  parameter int          CNT_W     = 32
) (
  input  logic       clk,
  input  logic       reset,
  led_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic             en_q, en_d;
  logic [31:0]      pattern_q, pattern_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [31:0]      cur_q, cur_d;
  logic             phase_q, phase_d;
  logic             led_we_q, led_we_d;
  logic [31:0]      led_wd_q, led_wd_d;

  logic             wr_any, wr_ctrl, wr_pat, wr_per;
  mode_e            wr_mode;
  logic             wr_go;
  logic             tick;
  logic             restart;
  logic [31:0]      restart_pat;

  // SHOW is read-only, so a write to it is not a CPU write at all.
  assign wr_any  = bus.cpu_we && (bus.cpu_addr != ADDR_SHOW);
  assign wr_ctrl = bus.cpu_we && (bus.cpu_addr == ADDR_CTRL);
  assign wr_pat  = bus.cpu_we && (bus.cpu_addr == ADDR_PATTERN);
  assign wr_per  = bus.cpu_we && (bus.cpu_addr == ADDR_PERIOD);
  assign wr_mode = mode_e'(bus.cpu_wd[1:0]);
  assign wr_go   = bus.cpu_wd[2] && engine_mode(wr_mode);

  led_period_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .run_i    (state_q == ST_RUN),
    .clr_i    (wr_any),
    .period_i (period_q),
    .tick_o   (tick)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    en_d        = en_q;
    pattern_d   = pattern_q;
    period_d    = period_q;
    cur_d       = cur_q;
    phase_d     = phase_q;
    led_we_d    = 1'b0;
    led_wd_d    = led_wd_q;
    restart     = 1'b0;
    restart_pat = pattern_q;

    if (wr_ctrl) begin
      mode_d = wr_mode;
      en_d   = bus.cpu_wd[2];
    end
    if (wr_pat) begin
      pattern_d   = bus.cpu_wd;
      restart_pat = bus.cpu_wd;
    end
    if (wr_per) period_d = CNT_W'(bus.cpu_wd);

    unique case (state_q)
      ST_IDLE: begin
        if (wr_ctrl && wr_go) begin
          state_d = ST_RUN;
          restart = 1'b1;
        end else if (wr_pat && !engine_mode(mode_q)) begin
          led_we_d = 1'b1;
          led_wd_d = bus.cpu_wd;
        end
      end
      ST_RUN: begin
        if (wr_ctrl) begin
          if (wr_go) begin
            restart = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            led_we_d = 1'b1;
            led_wd_d = OFF_VALUE;
          end
        end else if (wr_pat) begin
          restart = 1'b1;
        end else if (tick && !wr_any) begin
          // Blink frames follow the new phase: 1 shows dark, 0 shows the pattern.
          led_we_d = 1'b1;
          if (mode_q == MODE_BLINK) begin
            phase_d  = !phase_q;
            led_wd_d = phase_q ? pattern_q : OFF_VALUE;
          end else begin
            cur_d    = rotl1(cur_q);
            led_wd_d = rotl1(cur_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (restart) begin
      phase_d  = 1'b0;
      cur_d    = restart_pat;
      led_we_d = 1'b1;
      led_wd_d = restart_pat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_MANUAL;
      en_q      <= 1'b0;
      pattern_q <= '0;
      period_q  <= '0;
      cur_q     <= '0;
      phase_q   <= 1'b0;
      led_we_q  <= 1'b0;
      led_wd_q  <= OFF_VALUE;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      en_q      <= en_d;
      pattern_q <= pattern_d;
      period_q  <= period_d;
      cur_q     <= cur_d;
      phase_q   <= phase_d;
      led_we_q  <= led_we_d;
      led_wd_q  <= led_wd_d;
    end
  end

  always_comb begin
    bus.cpu_rd = '0;
    unique case (bus.cpu_addr)
      ADDR_CTRL:    bus.cpu_rd = {29'd0, en_q, mode_q};
      ADDR_PATTERN: bus.cpu_rd = pattern_q;
      ADDR_PERIOD:  bus.cpu_rd = 32'(period_q);
      ADDR_SHOW:    bus.cpu_rd = led_wd_q;
      default:      bus.cpu_rd = '0;
    endcase
  end

  assign bus.led_we = led_we_q;
  assign bus.led_wd = led_wd_q;

endmodule

// File: tb/tb_led_ctrl.sv
// Directed scenarios plus random CPU traffic against a frame-schedule model of led_ctrl.
module tb_led_ctrl;
  import led_ctrl_pkg::*;

  localparam logic [31:0] OFF = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset;

  led_ctrl_if bus();

  led_ctrl #(.OFF_VALUE(OFF), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: registers as the CPU sees them, plus a frame index and a countdown to the next frame.
  logic [2:0]  m_ctrl;
  logic [31:0] m_pat, m_per, m_wd;
  logic        m_we, m_run;
  int          m_k, m_left;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic int eff();
    return (m_per == 0) ? 1 : int'(m_per);
  endfunction

  function automatic logic [31:0] frame(input int k);
    logic [63:0] tmp;
    if (m_ctrl[1:0] == 2'd1) return (k % 2 == 1) ? OFF : m_pat;
    tmp = {m_pat, m_pat} << (k % 32);
    return tmp[63:32];
  endfunction

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {29'd0, m_ctrl};
      2'd1:    return m_pat;
      2'd2:    return m_per;
      default: return m_wd;
    endcase
  endfunction

  task automatic m_start();
    m_run  = 1'b1;
    m_k    = 0;
    m_left = eff();
    m_we   = 1'b1;
    m_wd   = frame(0);
  endtask

  task automatic m_step(input logic r, input logic we, input logic [1:0] a, input logic [31:0] wd);
    logic go, manual;
    if (r) begin
      m_ctrl = 3'd0; m_pat = '0; m_per = '0;
      m_run = 1'b0; m_k = 0; m_left = 0;
      m_we = 1'b0; m_wd = OFF;
      return;
    end
    m_we = 1'b0;
    if (we && a != 2'd3) begin
      case (a)
        2'd0: begin
          m_ctrl = wd[2:0];
          go = wd[2] && (wd[1:0] == 2'd1 || wd[1:0] == 2'd2);
          if (go) m_start();
          else if (m_run) begin
            m_run = 1'b0; m_we = 1'b1; m_wd = OFF;
          end
        end
        2'd1: begin
          manual = (m_ctrl[1:0] == 2'd0) || (m_ctrl[1:0] == 2'd3);
          m_pat = wd;
          if (m_run) m_start();
          else if (manual) begin
            m_we = 1'b1; m_wd = wd;
          end
        end
        default: begin
          m_per = wd;
          if (m_run) m_left = eff();
        end
      endcase
    end else if (m_run) begin
      m_left--;
      if (m_left == 0) begin
        m_k++;
        m_we   = 1'b1;
        m_wd   = frame(m_k);
        m_left = eff();
      end
    end
  endtask

  // One cycle: drive at the falling edge, check the read mux, clock, check outputs at the next falling edge.
  task automatic step(input logic we, input logic [1:0] a, input logic [31:0] wd);
    bus.cpu_we   = we;
    bus.cpu_addr = a;
    bus.cpu_wd   = wd;
    #1;
    if (!reset) chk("cpu_rd", bus.cpu_rd, exp_rd(a));
    @(posedge clk);
    m_step(reset, we, a, wd);
    @(negedge clk);
    chk("led_we", 32'(bus.led_we), 32'(m_we));
    chk("led_wd", bus.led_wd, m_wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'd0);
  endtask

  initial begin
    logic        r_we;
    logic [1:0]  r_a;
    logic [31:0] r_wd;

    reset        = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 2'd0;
    bus.cpu_wd   = '0;
    m_step(1'b1, 1'b0, 2'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", 32'(bus.led_we), 32'd0);
    chk("rst_wd", bus.led_wd, OFF);
    reset = 1'b0;
    idle(2);
    bus.cpu_addr = 2'd0; #1;
    chk("rst_ctrl", bus.cpu_rd, 32'd0);

    // MANUAL
    step(1'b1, 2'd1, 32'h0000_00F0);
    chk("man_we", 32'(bus.led_we), 32'd1);
    chk("man_wd", bus.led_wd, 32'h0000_00F0);
    idle(3);
    chk("man_quiet", 32'(bus.led_we), 32'd0);

    // BLINK, period 4
    step(1'b1, 2'd1, 32'hA5A5_A5A5);
    step(1'b1, 2'd2, 32'd4);
    step(1'b1, 2'd0, 32'd5);
    chk("blink_f0", bus.led_wd, 32'hA5A5_A5A5);
    idle(4);
    chk("blink_f1_we", 32'(bus.led_we), 32'd1);
    chk("blink_f1", bus.led_wd, 32'hFFFF_FFFF);
    idle(4);
    chk("blink_f2", bus.led_wd, 32'hA5A5_A5A5);
    idle(2);

    // Disable mid-run
    step(1'b1, 2'd0, 32'd0);
    chk("dis_we", 32'(bus.led_we), 32'd1);
    chk("dis_wd", bus.led_wd, OFF);
    idle(6);
    chk("dis_quiet", 32'(bus.led_we), 32'd0);

    // SHIFT wrap, period 0
    step(1'b1, 2'd1, 32'h8000_0001);
    step(1'b1, 2'd2, 32'd0);
    step(1'b1, 2'd0, 32'd6);
    chk("shift_f0", bus.led_wd, 32'h8000_0001);
    idle(1);
    chk("shift_f1", bus.led_wd, 32'h0000_0003);
    idle(1);
    chk("shift_f2", bus.led_wd, 32'h0000_0006);
    idle(3);

    // Collision: PATTERN write in the tick cycle of BLINK period 3
    step(1'b1, 2'd0, 32'd0);
    step(1'b1, 2'd2, 32'd3);
    step(1'b1, 2'd0, 32'd5);
    idle(2);
    step(1'b1, 2'd1, 32'h0000_0001);
    chk("col_wd", bus.led_wd, 32'h0000_0001);
    idle(2);
    chk("col_gap", 32'(bus.led_we), 32'd0);
    idle(1);
    chk("col_tick_we", 32'(bus.led_we), 32'd1);
    chk("col_tick_wd", bus.led_wd, OFF);
    idle(1);

    // Reset mid-run
    reset = 1'b1;
    step(1'b0, 2'd3, 32'd0);
    chk("rrun_we", 32'(bus.led_we), 32'd0);
    chk("rrun_wd", bus.led_wd, OFF);
    reset = 1'b0;
    bus.cpu_addr = 2'd3; #1;
    chk("rrun_show", bus.cpu_rd, OFF);
    step(1'b0, 2'd3, 32'd0);
    chk("rrun_noframe", 32'(bus.led_we), 32'd0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 249) == 0);
      r_we  = ($urandom_range(0, 3) == 0);
      r_a   = 2'($urandom_range(0, 3));
      case (r_a)
        2'd2:    r_wd = 32'($urandom_range(0, 5));
        2'd0:    r_wd = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 7));
        default: r_wd = 32'($urandom);
      endcase
      step(r_we, r_a, r_wd);
    end
    reset = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
